lsu_simple: RTL
===============

LSU_SIMPLE -- requirements
Module: lsu_simple

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, address width; WORD_WIDTH, default 32, register/store data width; BLOCK_WIDTH, default 64, main-memory response block width; ROB_ID_WIDTH, default 4, ROB tag width.
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports are listed below, one per line: name, direction, width, meaning.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst_aH  in  1  synchronous active-high reset.
REQ-005 flush  in  1  branch-mispredict squash, shared with the integer issue queue and the front end.
REQ-006 issue_valid / issue_ready  in / out  1 / 1  LSQ issue handshake.
REQ-007 issue_is_store  in  1  1=store, 0=load.
REQ-008 issue_size  in  3  one-hot {Word, Halfword, Byte}.
REQ-009 issue_sext  in  1  sign-extend load result.
REQ-010 issue_base, issue_imm, issue_st_data  in  ADDR_WIDTH, ADDR_WIDTH, WORD_WIDTH  base, offset, store data.
REQ-011 issue_rob_id  in  ROB_ID_WIDTH  tag of the issued op.
REQ-012 req_main_mem_valid / req_main_mem_ready  out / in  1 / 1  load read-request handshake.
REQ-013 req_main_mem_addr, req_main_mem_size  out  ADDR_WIDTH, 3  request address (block-aligned) and size.
REQ-014 recv_main_mem_valid, recv_main_mem_lsu_aL_ifu_aH, recv_main_mem_addr, recv_main_mem_data  in  1, 1, ADDR_WIDTH, BLOCK_WIDTH  shared memory response bus.
REQ-015 send_en_main_mem, send_main_mem_addr, send_size_main_mem, send_main_mem_data  out  1, ADDR_WIDTH, 3, WORD_WIDTH  store write port.
REQ-016 ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data  out  1, ROB_ID_WIDTH, WORD_WIDTH  load result broadcast.
REQ-017 misalign_valid, misalign_rob_id  out  1, ROB_ID_WIDTH  misaligned-access report.

Function
REQ-018 FSM states SHALL be IDLE, ST, LD_REQ, LD_WAIT, BCAST, MIS, DRAIN; one op in flight at a time.
REQ-019 issue_ready SHALL be 1 only in IDLE; an issue is accepted when issue_valid && issue_ready && !flush; accepted fields are registered.
REQ-020 Effective address SHALL be issue_base + issue_imm, modulo 2^ADDR_WIDTH, no overflow detection.
REQ-021 Misaligned (Word with addr[1:0]!=0, Halfword with addr[0]!=0) SHALL go to MIS; MIS drives misalign_valid=1 for exactly one cycle, with no memory traffic, then returns to IDLE.
REQ-022 Aligned store SHALL go to ST; ST drives send_en_main_mem=1 for exactly one cycle with registered addr, size, and data (low-aligned), then returns to IDLE; flush does not cancel ST.
REQ-023 Aligned load SHALL go to LD_REQ; req_main_mem_valid=1 is held with stable addr (addr with low log2(BLOCK_WIDTH/8) bits cleared) until req_main_mem_ready, then the FSM moves to LD_WAIT.
REQ-024 LD_WAIT SHALL capture only when recv_main_mem_valid && !recv_main_mem_lsu_aL_ifu_aH && recv_main_mem_addr equals the request address; IFU-directed or non-matching responses are ignored.
REQ-025 Load data SHALL be extracted from the byte offset addr mod (BLOCK_WIDTH/8), then zero- or sign-extended per issue_sext to WORD_WIDTH, and registered.
REQ-026 BCAST SHALL drive ld_broadcast_valid=1 for exactly one cycle with the captured rob_id and data, then return to IDLE; total load latency is 3 cycles plus request stall plus memory latency.
REQ-027 flush in LD_REQ before the handshake, or in BCAST or MIS, SHALL return the FSM to IDLE with no broadcast or report that cycle.
REQ-028 flush in LD_REQ coincident with req_main_mem_ready, or in LD_WAIT, SHALL go to DRAIN; DRAIN discards the matching response and then returns to IDLE with no broadcast; if the matching response arrives in the flush cycle itself, the FSM goes directly to IDLE.
REQ-029 flush in IDLE SHALL block acceptance that cycle.

Reset
REQ-030 rst_aH SHALL force IDLE and zero all outputs and registers except issue_ready, which is 1 on the first cycle after reset; reset takes priority over flush and over any in-flight op, and a response arriving after reset is ignored.

Verification
REQ-031 Load word, base=0x100, imm=0x8, sext=0, mem returns addr 0x108 block with word 0xDEADBEEF at offset 0 -> one ld_broadcast_valid pulse, data 0xDEADBEEF, correct rob_id.
REQ-032 Load byte, sext=1, addr 0x203, byte 0x80 -> data 0xFFFFFF80; same with sext=0 -> 0x00000080.
REQ-033 Store halfword, addr 0x40, data 0x1234ABCD -> single send_en_main_mem pulse with addr 0x40, size 3'b010, data 0x1234ABCD.
REQ-034 Load word at addr 0x102 -> misalign_valid pulse, no req_main_mem_valid, and issue_ready back to 1 two cycles after acceptance.
REQ-035 Load outstanding, an IFU response with the same addr arrives, then flush in LD_WAIT, then the LSU response arrives -> no broadcast; FSM in IDLE the cycle after the discarded response.
REQ-036 rst_aH asserted in LD_WAIT, then the matching response arrives -> no broadcast, all outputs 0, issue_ready=1.

Source files
------------

// File: rtl/lsu_simple.sv
// Single-op-in-flight load/store unit: address generation, alignment check,
// block-read loads with byte extraction, one-cycle store writes, and flush/drain handling.
module lsu_simple #(
  parameter int ADDR_WIDTH   = 32,
  parameter int WORD_WIDTH   = 32,
  parameter int BLOCK_WIDTH  = 64,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_aH,
  input  logic                    flush,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic                    issue_is_store,
  input  logic [2:0]              issue_size,
  input  logic                    issue_sext,
  input  logic [ADDR_WIDTH-1:0]   issue_base,
  input  logic [ADDR_WIDTH-1:0]   issue_imm,
  input  logic [WORD_WIDTH-1:0]   issue_st_data,
  input  logic [ROB_ID_WIDTH-1:0] issue_rob_id,
  output logic                    req_main_mem_valid,
  input  logic                    req_main_mem_ready,
  output logic [ADDR_WIDTH-1:0]   req_main_mem_addr,
  output logic [2:0]              req_main_mem_size,
  input  logic                    recv_main_mem_valid,
  input  logic                    recv_main_mem_lsu_aL_ifu_aH,
  input  logic [ADDR_WIDTH-1:0]   recv_main_mem_addr,
  input  logic [BLOCK_WIDTH-1:0]  recv_main_mem_data,
  output logic                    send_en_main_mem,
  output logic [ADDR_WIDTH-1:0]   send_main_mem_addr,
  output logic [2:0]              send_size_main_mem,
  output logic [WORD_WIDTH-1:0]   send_main_mem_data,
  output logic                    ld_broadcast_valid,
  output logic [ROB_ID_WIDTH-1:0] ld_broadcast_rob_id,
  output logic [WORD_WIDTH-1:0]   ld_broadcast_reg_data,
  output logic                    misalign_valid,
  output logic [ROB_ID_WIDTH-1:0] misalign_rob_id
);
  localparam int OFF_W = $clog2(BLOCK_WIDTH / 8);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ST      = 3'd1;
  localparam logic [2:0] LD_REQ  = 3'd2;
  localparam logic [2:0] LD_WAIT = 3'd3;
  localparam logic [2:0] BCAST   = 3'd4;
  localparam logic [2:0] MIS     = 3'd5;
  localparam logic [2:0] DRAIN   = 3'd6;

  localparam logic [2:0] SIZE_W = 3'b100;
  localparam logic [2:0] SIZE_H = 3'b010;

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SIZE_W:  bad = (lo != 2'b00);
      SIZE_H:  bad = lo[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Shift the addressed byte down to bit 0, then keep and extend the access width.
  function automatic logic [WORD_WIDTH-1:0] extract(input logic [BLOCK_WIDTH-1:0] blk,
                                                    input logic [OFF_W-1:0] off,
                                                    input logic [2:0] size,
                                                    input logic sext);
    logic [WORD_WIDTH-1:0] low;
    logic [WORD_WIDTH-1:0] res;
    low = WORD_WIDTH'(blk >> {off, 3'b000});
    case (size)
      SIZE_W:  res = low;
      SIZE_H:  res = {{(WORD_WIDTH-16){sext & low[15]}}, low[15:0]};
      default: res = {{(WORD_WIDTH-8){sext & low[7]}}, low[7:0]};
    endcase
    return res;
  endfunction

  logic [2:0]              state_r;
  logic [2:0]              state_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [2:0]              size_r;
  logic                    sext_r;
  logic [WORD_WIDTH-1:0]   st_data_r;
  logic [ROB_ID_WIDTH-1:0] rob_r;
  logic [WORD_WIDTH-1:0]   ld_data_r;
  logic [ADDR_WIDTH-1:0]   ea_s;
  logic [ADDR_WIDTH-1:0]   blk_addr_s;
  logic                    accept_s;
  logic                    resp_hit_s;

  assign ea_s       = issue_base + issue_imm;
  assign blk_addr_s = {addr_r[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign accept_s   = issue_valid & issue_ready & ~flush;
  assign resp_hit_s = recv_main_mem_valid & ~recv_main_mem_lsu_aL_ifu_aH &
                      (recv_main_mem_addr == blk_addr_s);

  // Next-state logic; a handshake that coincides with flush leaves a response to drain.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s)                                state_s = IDLE;
        else if (is_misaligned(issue_size, ea_s[1:0])) state_s = MIS;
        else if (issue_is_store)                      state_s = ST;
        else                                          state_s = LD_REQ;
      end
      ST:     state_s = IDLE;
      LD_REQ: begin
        if (req_main_mem_ready) state_s = flush ? DRAIN : LD_WAIT;
        else if (flush)         state_s = IDLE;
        else                    state_s = LD_REQ;
      end
      LD_WAIT: begin
        if (resp_hit_s) state_s = flush ? IDLE : BCAST;
        else if (flush) state_s = DRAIN;
        else            state_s = LD_WAIT;
      end
      BCAST:   state_s = IDLE;
      MIS:     state_s = IDLE;
      DRAIN: begin
        if (resp_hit_s) state_s = IDLE;
        else            state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, captured issue fields and load result.
  always_ff @(posedge clk) begin
    if (rst_aH) begin
      state_r   <= IDLE;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      size_r    <= 3'b000;
      sext_r    <= 1'b0;
      st_data_r <= {WORD_WIDTH{1'b0}};
      rob_r     <= {ROB_ID_WIDTH{1'b0}};
      ld_data_r <= {WORD_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        addr_r    <= ea_s;
        size_r    <= issue_size;
        sext_r    <= issue_sext;
        st_data_r <= issue_st_data;
        rob_r     <= issue_rob_id;
      end
      if ((state_r == LD_WAIT) && resp_hit_s && !flush) begin
        ld_data_r <= extract(recv_main_mem_data, addr_r[OFF_W-1:0], size_r, sext_r);
      end
    end
  end

  assign issue_ready           = (state_r == IDLE);
  assign req_main_mem_valid    = (state_r == LD_REQ);
  assign req_main_mem_addr     = blk_addr_s;
  assign req_main_mem_size     = size_r;
  assign send_en_main_mem      = (state_r == ST);
  assign send_main_mem_addr    = addr_r;
  assign send_size_main_mem    = size_r;
  assign send_main_mem_data    = st_data_r;
  // Flush suppresses a pending broadcast or report in the same cycle.
  assign ld_broadcast_valid    = (state_r == BCAST) & ~flush;
  assign ld_broadcast_rob_id   = rob_r;
  assign ld_broadcast_reg_data = ld_data_r;
  assign misalign_valid        = (state_r == MIS) & ~flush;
  assign misalign_rob_id       = rob_r;
endmodule
